// File: rtl/data_read_cmd_gen.sv
// data_read_cmd_gen: turns a (byte address, byte length) job into a stream of
// cacheline-aligned read commands, throttled by a response credit counter.
// Optional stall statistics are enabled with macro DATA_READ_CMD_GEN_STATS_EN.
module data_read_cmd_gen #(
    parameter int unsigned CACHELINE_SIZE  = 128,
    parameter logic [7:0]  CU_ID           = 8'hFC,
    parameter int unsigned MAX_OUTSTANDING = 256
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [63:0] job_addr,
    input  logic [31:0] job_size,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [63:0] cmd_addr,
    output logic [7:0]  cmd_cu_id,
    output logic        cmd_last,
    input  logic        rsp_valid,
`ifdef DATA_READ_CMD_GEN_STATS_EN
    output logic [31:0] stall_cycles,
`endif
    output logic        done
);

    localparam int          LINE_SHIFT = $clog2(CACHELINE_SIZE);
    localparam logic [63:0] LINE_BYTES = 64'(CACHELINE_SIZE);
    localparam logic [63:0] LINE_MASK  = ~(LINE_BYTES - 64'd1);

    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] size_q, size_d;
    logic [63:0] remaining_q, remaining_d;
    logic [8:0]  outstanding_q, outstanding_d;
    logic [63:0] cmd_addr_q, cmd_addr_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_last_q, cmd_last_d;

    logic        job_accept, cmd_hs, rsp_eff;
    logic [63:0] start_addr, end_addr, line_cnt;

    assign job_accept = job_valid && job_ready;
    assign cmd_hs     = cmd_valid_q && cmd_ready;
    // A response with no command in flight is spurious and must not wrap the counter.
    assign rsp_eff    = rsp_valid && (outstanding_q != 9'd0);

    // Line-range arithmetic is done in 64 bits so addr+size never truncates.
    assign start_addr = addr_q & LINE_MASK;
    assign end_addr   = (addr_q + {32'd0, size_q} - 64'd1) & LINE_MASK;
    assign line_cnt   = ((end_addr - start_addr) >> LINE_SHIFT) + 64'd1;

    // State register and all datapath flops.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            cmd_addr_q    <= '0;
            cmd_valid_q   <= 1'b0;
            cmd_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            cmd_addr_q    <= cmd_addr_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_last_q    <= cmd_last_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (job_accept) state_d = CALC;
            CALC:    state_d = (size_q == 32'd0) ? DONE : ISSUE;
            ISSUE:   if (cmd_hs && remaining_q == 64'd1) state_d = DRAIN;
            DRAIN:   if (outstanding_d == 9'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: job capture, line counter, credits, command registers.
    always_comb begin
        addr_d        = addr_q;
        size_d        = size_q;
        remaining_d   = remaining_q;
        outstanding_d = outstanding_q;
        cmd_addr_d    = cmd_addr_q;

        if (job_accept) begin
            addr_d = job_addr;
            size_d = job_size;
        end

        if (state_q == CALC) begin
            remaining_d = (size_q == 32'd0) ? 64'd0 : line_cnt;
            cmd_addr_d  = start_addr;
        end else if (cmd_hs) begin
            remaining_d = remaining_q - 64'd1;
            cmd_addr_d  = cmd_addr_q + LINE_BYTES;
        end

        case ({cmd_hs, rsp_eff})
            2'b10:   outstanding_d = outstanding_q + 9'd1;
            2'b01:   outstanding_d = outstanding_q - 9'd1;
            default: outstanding_d = outstanding_q;
        endcase

        // Once presented, a command stays valid: without a handshake credits only grow.
        cmd_valid_d = (state_d == ISSUE) && (remaining_d != 64'd0) &&
                      ({23'd0, outstanding_d} < MAX_OUTSTANDING);
        cmd_last_d  = (state_d == ISSUE) && (remaining_d == 64'd1);
    end

    // Output decode.
    always_comb begin
        job_ready = (state_q == IDLE) && !rst;
        done      = (state_q == DONE) && !rst;
        cmd_valid = cmd_valid_q;
        cmd_addr  = cmd_addr_q;
        cmd_last  = cmd_last_q;
        cmd_cu_id = CU_ID;
    end

`ifdef DATA_READ_CMD_GEN_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Back-pressure counter: saturating, cleared per job, frozen between jobs.
    always_comb begin
        stall_d = stall_q;
        if (job_accept)
            stall_d = '0;
        else if (cmd_valid_q && !cmd_ready && stall_q != '1)
            stall_d = stall_q + 32'd1;
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`endif

endmodule
